enigma_step_ctrl: RTL and testbench

- Upstream stepping controller for the three-rotor Enigma datapath; sits between the raw KEY pushbutton and the rotor_0_25 instances.
- Synchronises and debounces the key, then converts each accepted press into per-rotor single-cycle step pulses using Enigma notch rules, including the middle-rotor double step.
- Owns the authoritative rotor positions, which drive the rotors and the LEDG/HEX displays.

---
 rtl/enigma_pkg.sv | 26 ++
 rtl/key_debounce.sv | 88 ++++++++
 rtl/enigma_step_ctrl.sv | 74 +++++++
 tb/tb_enigma_step_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/enigma_pkg.sv
// Shared constants, debounce state encoding and mod-26 position helpers for the Enigma stepping logic.
// Pure definitions; no latency, no backpressure.
package enigma_pkg;

   localparam int N_POS       = 26;
   localparam int POS_W       = 5;
   localparam int NOTCH_R_DEF = 16;  // Q
   localparam int NOTCH_M_DEF = 4;   // E

   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } deb_state_t;

   // Also folds any out-of-range position back to 0.
   function automatic logic [POS_W-1:0] pos_inc(input logic [POS_W-1:0] p);
      return (p >= POS_W'(N_POS - 1)) ? '0 : p + POS_W'(1);
   endfunction

   function automatic logic [POS_W-1:0] pos_clamp(input logic [POS_W-1:0] p);
      return (p > POS_W'(N_POS - 1)) ? '0 : p;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchronises the raw active-low key and debounces it; accept pulses once per press.
// Latency: 2 sync + DEBOUNCE_CYCLES cycles to accept (combinational strobe); no backpressure.
module key_debounce
   import enigma_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic resetn,
   input  logic key_n,
   output logic accept
);

   localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
   // The sample that completes the window is the one that moves the FSM on.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_q1;
   logic             sync_q2;
   deb_state_t       state_q;
   deb_state_t       state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync_q1 <= 1'b1;
         sync_q2 <= 1'b1;
      end else begin
         sync_q1 <= key_n;
         sync_q2 <= sync_q1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= RELEASED;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      case (state_q)
         RELEASED: begin
            cnt_d = '0;
            if (!sync_q2) state_d = PRESS_WAIT;
         end
         PRESS_WAIT: begin
            if (sync_q2) begin
               state_d = RELEASED;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = PRESSED;
               cnt_d   = '0;
               accept  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         PRESSED: begin
            cnt_d = '0;
            if (sync_q2) state_d = RELEASE_WAIT;
         end
         RELEASE_WAIT: begin
            if (!sync_q2) begin
               state_d = PRESSED;
               cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d = RELEASED;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = RELEASED;
            cnt_d   = '0;
         end
      endcase
   end

endmodule

// File: rtl/enigma_step_ctrl.sv
// Turns debounced key presses into Enigma rotor step pulses and owns the rotor positions.
// Latency: key_evt/step_*/pos_* one cycle after accept (2 + DEBOUNCE_CYCLES + 1 from key fall); no backpressure.
module enigma_step_ctrl
   import enigma_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int NOTCH_R         = NOTCH_R_DEF,
   parameter int NOTCH_M         = NOTCH_M_DEF
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             key_n,
   input  logic             load_init,
   input  logic [POS_W-1:0] init_r,
   input  logic [POS_W-1:0] init_m,
   input  logic [POS_W-1:0] init_l,
   output logic             key_evt,
   output logic             step_r,
   output logic             step_m,
   output logic             step_l,
   output logic [POS_W-1:0] pos_r,
   output logic [POS_W-1:0] pos_m,
   output logic [POS_W-1:0] pos_l
);

   logic accept;
   logic hit_r;
   logic hit_m;
   logic adv_m;

   key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_key_debounce (
      .clk    (clk),
      .resetn (resetn),
      .key_n  (key_n),
      .accept (accept)
   );

   // Notch tests use pre-step positions; hit_m alone yields the middle-rotor double step.
   assign hit_r = (pos_r == POS_W'(NOTCH_R));
   assign hit_m = (pos_m == POS_W'(NOTCH_M));
   assign adv_m = hit_r | hit_m;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         key_evt <= 1'b0;
         step_r  <= 1'b0;
         step_m  <= 1'b0;
         step_l  <= 1'b0;
         pos_r   <= '0;
         pos_m   <= '0;
         pos_l   <= '0;
      end else begin
         key_evt <= accept;
         step_r  <= 1'b0;
         step_m  <= 1'b0;
         step_l  <= 1'b0;
         if (load_init) begin
            pos_r <= pos_clamp(init_r);
            pos_m <= pos_clamp(init_m);
            pos_l <= pos_clamp(init_l);
         end else if (accept) begin
            step_r <= 1'b1;
            step_m <= adv_m;
            step_l <= hit_m;
            pos_r  <= pos_inc(pos_r);
            if (adv_m) pos_m <= pos_inc(pos_m);
            if (hit_m) pos_l <= pos_inc(pos_l);
         end
      end
   end

endmodule

// File: tb/tb_enigma_step_ctrl.sv
// Directed bench for enigma_step_ctrl with DEBOUNCE_CYCLES = 4; a monitor checks every key_evt against a scoreboard.
module tb_enigma_step_ctrl;

   logic       clk = 1'b0;
   logic       resetn;
   logic       key_n;
   logic       load_init;
   logic [4:0] init_r, init_m, init_l;
   logic       key_evt, step_r, step_m, step_l;
   logic [4:0] pos_r, pos_m, pos_l;

   always #5 clk = ~clk;

   enigma_step_ctrl #(
      .DEBOUNCE_CYCLES(4),
      .NOTCH_R(16),
      .NOTCH_M(4)
   ) dut (
      .clk       (clk),
      .resetn    (resetn),
      .key_n     (key_n),
      .load_init (load_init),
      .init_r    (init_r),
      .init_m    (init_m),
      .init_l    (init_l),
      .key_evt   (key_evt),
      .step_r    (step_r),
      .step_m    (step_m),
      .step_l    (step_l),
      .pos_r     (pos_r),
      .pos_m     (pos_m),
      .pos_l     (pos_l)
   );

   typedef struct {
      int         cyc;
      logic [2:0] st;   // {step_l, step_m, step_r}
      logic [4:0] r;
      logic [4:0] m;
      logic [4:0] l;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every key_evt must match the oldest expected event, in value and cycle.
   always @(negedge clk) begin
      if (resetn) begin
         if (key_evt) begin
            total++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL unexpected_key_evt cyc=%0d got steps=%b pos=%0d/%0d/%0d want no event",
                        cyc, {step_l, step_m, step_r}, pos_r, pos_m, pos_l);
            end else begin
               mon_e = sb.pop_front();
               if (cyc != mon_e.cyc) begin
                  bad++;
                  $display("FAIL evt_timing got cyc=%0d want cyc=%0d", cyc, mon_e.cyc);
               end
               total++;
               if ({step_l, step_m, step_r} != mon_e.st || pos_r != mon_e.r ||
                   pos_m != mon_e.m || pos_l != mon_e.l) begin
                  bad++;
                  $display("FAIL evt_value got steps(lmr)=%b r=%0d m=%0d l=%0d want steps=%b r=%0d m=%0d l=%0d",
                           {step_l, step_m, step_r}, pos_r, pos_m, pos_l,
                           mon_e.st, mon_e.r, mon_e.m, mon_e.l);
               end
            end
         end else if (step_r || step_m || step_l) begin
            total++;
            bad++;
            $display("FAIL stray_step cyc=%0d got steps(lmr)=%b want 000 without key_evt",
                     cyc, {step_l, step_m, step_r});
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout got no finish want finish before 10000 cycles");
      $fatal(1, "timeout");
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_evt(input int at, input logic [2:0] st,
                             input logic [4:0] r, input logic [4:0] m, input logic [4:0] l);
      exp_t e;
      e.cyc = at; e.st = st; e.r = r; e.m = m; e.l = l;
      sb.push_back(e);
   endtask

   // Clean press: event expected 7 cycles after the fall, then a clean release.
   task automatic press(input int hold, input logic [2:0] st,
                        input logic [4:0] r, input logic [4:0] m, input logic [4:0] l);
      key_n = 1'b0;
      expect_evt(cyc + 7, st, r, m, l);
      tick(hold);
      key_n = 1'b1;
      tick(12);
   endtask

   task automatic check_pos(input string name, input logic [4:0] r,
                            input logic [4:0] m, input logic [4:0] l);
      total++;
      if (pos_r != r || pos_m != m || pos_l != l) begin
         bad++;
         $display("FAIL %s got r=%0d m=%0d l=%0d want r=%0d m=%0d l=%0d",
                  name, pos_r, pos_m, pos_l, r, m, l);
      end
   endtask

   task automatic check_idle(input string name);
      total++;
      if ({key_evt, step_l, step_m, step_r} != 4'b0 || pos_r != 5'd0 ||
          pos_m != 5'd0 || pos_l != 5'd0) begin
         bad++;
         $display("FAIL %s got evt=%b steps=%b r=%0d m=%0d l=%0d want all zero",
                  name, key_evt, {step_l, step_m, step_r}, pos_r, pos_m, pos_l);
      end
   endtask

   task automatic load(input logic [4:0] r, input logic [4:0] m, input logic [4:0] l);
      init_r = r; init_m = m; init_l = l;
      load_init = 1'b1;
      tick(1);
      load_init = 1'b0;
      tick(1);
   endtask

   initial begin
      resetn    = 1'b0;
      key_n     = 1'b1;
      load_init = 1'b0;
      init_r    = '0;
      init_m    = '0;
      init_l    = '0;
      tick(3);
      check_idle("reset_state");
      resetn = 1'b1;
      tick(3);

      // 1: clean press held 20 cycles -> single event
      press(20, 3'b001, 5'd1, 5'd0, 5'd0);

      // 2: bouncy press, then bouncy release
      key_n = 1'b0;
      expect_evt(cyc + 10, 3'b001, 5'd2, 5'd0, 5'd0);
      tick(2);  key_n = 1'b1;
      tick(1);  key_n = 1'b0;
      tick(10); key_n = 1'b1;
      tick(2);  key_n = 1'b0;
      tick(1);  key_n = 1'b1;
      tick(12);
      check_pos("after_bounce", 5'd2, 5'd0, 5'd0);

      // 3: right-rotor carry, then middle-rotor double step
      load(5'd16, 5'd3, 5'd0);
      check_pos("load_16_3_0", 5'd16, 5'd3, 5'd0);
      press(8, 3'b011, 5'd17, 5'd4, 5'd0);
      press(8, 3'b111, 5'd18, 5'd5, 5'd1);

      // 4: wraparound cases
      load(5'd25, 5'd10, 5'd25);
      check_pos("load_25_10_25", 5'd25, 5'd10, 5'd25);
      press(8, 3'b001, 5'd0, 5'd10, 5'd25);
      load(5'd16, 5'd25, 5'd25);
      press(8, 3'b011, 5'd17, 5'd0, 5'd25);

      // 5: load_init held across an accept, out-of-range init clamps to 0
      init_r = 5'd30; init_m = 5'd2; init_l = 5'd7;
      load_init = 1'b1;
      press(8, 3'b000, 5'd0, 5'd2, 5'd7);
      load_init = 1'b0;
      tick(1);
      check_pos("after_load_hold", 5'd0, 5'd2, 5'd7);

      // 6: reset while in PRESS_WAIT with key held
      key_n = 1'b0;
      tick(4);
      resetn = 1'b0;
      #1;
      check_idle("mid_reset");
      tick(3);
      resetn = 1'b1;
      expect_evt(cyc + 7, 3'b001, 5'd1, 5'd0, 5'd0);
      tick(10);
      key_n = 1'b1;
      tick(12);
      check_pos("after_reset_press", 5'd1, 5'd0, 5'd0);

      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL pending_events got %0d outstanding want 0", sb.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
